// File: rtl/z80_host_pkg.sv
// -----------------------------------------------------------------------------
// z80_host_pkg
// Shared definitions for the Z80 host key-interrupt controller:
//   - INT and NMI FSM state encodings
//   - reset values of the programmable vector and enable registers
//   - synchronizer depth used by the key debouncers
// -----------------------------------------------------------------------------
package z80_host_pkg;

  // Maskable-interrupt request FSM.
  typedef enum logic [1:0] {
    INT_ST_IDLE = 2'b00,  // no request outstanding
    INT_ST_PEND = 2'b01,  // nINT asserted, waiting for INTA
    INT_ST_ACK  = 2'b10   // INTA seen, waiting for nIORQ to rise
  } int_state_e;

  // Non-maskable-interrupt pulse FSM.
  typedef enum logic {
    NMI_ST_IDLE  = 1'b0,
    NMI_ST_PULSE = 1'b1   // nNMI held low for NMI_PULSE cycles
  } nmi_state_e;

  // Vector register after reset: 8'h80 (a sensible IM2 table offset).
  localparam logic [7:0] VEC_RESET = 8'h80;

  // Maskable interrupt is enabled out of reset.
  localparam logic       EN_RESET  = 1'b1;

  // Flops in each key synchronizer chain.
  localparam int         SYNC_STAGES = 2;

endpackage : z80_host_pkg

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronizes one asynchronous push-button, debounces it and reports a
// one-cycle pulse when the debounced level goes from 0 to 1.
//
// The debounced level only changes after the synchronized level has disagreed
// with it for DEB_CYCLES consecutive cycles; any agreement restarts the count.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   key_raw  in   raw active-high button, asynchronous to clk
//   rise     out  registered one-cycle pulse on a debounced 0->1 transition
// -----------------------------------------------------------------------------
module key_debounce
  import z80_host_pkg::*;
#(
  parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic rise
);

  // Count value at which the debounced level is allowed to flip.
  localparam logic [15:0] CNT_LAST = DEB_CYCLES - 16'd1;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   rise_q, rise_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and no latch is inferred.
    sync_d = {sync_q[SYNC_STAGES-2:0], key_raw};
    cnt_d  = cnt_q;
    db_d   = db_q;

    if (synced == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Stable long enough: accept the new level and start over.
      db_d  = synced;
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 16'd1;
    end

    rise_d = db_d & ~db_q;
  end

  // NOTE: every flop here is a plain register with an async reset value; the
  // synchronizer is cleared too so no stale key level survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // which is what makes the synchronizer a true two-stage chain.
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule : key_debounce

// File: rtl/key_intr_ctrl.sv
// -----------------------------------------------------------------------------
// key_intr_ctrl
// Turns two push buttons into Z80 interrupts:
//   KEY_INT -> maskable request on nINT (level, held until acknowledged)
//   KEY_NMI -> fixed-length low pulse on nNMI
// Two IO registers are decoded on A[15:8]:
//   VEC_PORT    : 8-bit vector returned during interrupt acknowledge
//   VEC_PORT+1  : bit0 = maskable interrupt enable
//
// Ports:
//   CLK         in   CPU clock
//   nRESET      in   asynchronous active-low reset
//   KEY_INT     in   raw button for the maskable interrupt
//   KEY_NMI     in   raw button for the NMI
//   nM1/nIORQ/nWR in CPU bus strobes, active-low
//   A_HI[7:0]   in   CPU address A[15:8]
//   D_IN[7:0]   in   CPU data bus
//   nINT        out  maskable interrupt request, active-low level
//   nNMI        out  NMI request, active-low pulse
//   VEC[7:0]    out  vector register contents
//   VEC_OE      out  high while M1 and IORQ are both low (INTA)
// -----------------------------------------------------------------------------
module key_intr_ctrl
  import z80_host_pkg::*;
#(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter int unsigned NMI_PULSE  = 4,
  parameter logic [7:0]  VEC_PORT   = 8'h04
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       KEY_INT,
  input  logic       KEY_NMI,
  input  logic       nM1,
  input  logic       nIORQ,
  input  logic       nWR,
  input  logic [7:0] A_HI,
  input  logic [7:0] D_IN,
  output logic       nINT,
  output logic       nNMI,
  output logic [7:0] VEC,
  output logic       VEC_OE
);

  localparam logic [7:0] EN_PORT = VEC_PORT + 8'd1;

  // Pulse counter sized for 0 .. NMI_PULSE-1.
  localparam int                PCNT_W    = (NMI_PULSE > 1) ? $clog2(NMI_PULSE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(NMI_PULSE - 1);

  // ---------------------------------------------------------------------------
  // Key front ends
  // ---------------------------------------------------------------------------
  logic int_rise;
  logic nmi_rise;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_int (
    .clk     (CLK),
    .rst_n   (nRESET),
    .key_raw (KEY_INT),
    .rise    (int_rise)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_nmi (
    .clk     (CLK),
    .rst_n   (nRESET),
    .key_raw (KEY_NMI),
    .rise    (nmi_rise)
  );

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic       inta;
  logic       io_wr_now;
  logic       io_wr_seen_q, io_wr_seen_d;
  logic       io_wr;
  logic       vec_wr;
  logic       en_wr;
  logic [7:0] vec_q, vec_d;
  logic       en_q, en_d;

  assign inta      = ~nM1 & ~nIORQ;
  assign io_wr_now = ~nIORQ & ~nWR & nM1;
  // A write strobe spans several clocks; act only on its first one.
  assign io_wr     = io_wr_now & ~io_wr_seen_q;
  assign vec_wr    = io_wr & (A_HI == VEC_PORT);
  assign en_wr     = io_wr & (A_HI == EN_PORT);

  always_comb begin
    io_wr_seen_d = io_wr_now;
    vec_d        = vec_wr ? D_IN    : vec_q;
    en_d         = en_wr  ? D_IN[0] : en_q;
  end

  // ---------------------------------------------------------------------------
  // Interrupt events
  // ---------------------------------------------------------------------------
  logic int_ev;
  logic nmi_ev;

  // An INT key press while disabled is simply lost.
  assign int_ev = int_rise & en_q;
  assign nmi_ev = nmi_rise;

  // ---------------------------------------------------------------------------
  // FSM state registers
  // ---------------------------------------------------------------------------
  int_state_e        int_state_q, int_state_d;
  logic              retrig_q, retrig_d;
  nmi_state_e        nmi_state_q, nmi_state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      int_state_q  <= INT_ST_IDLE;
      retrig_q     <= 1'b0;
      nmi_state_q  <= NMI_ST_IDLE;
      pcnt_q       <= '0;
      io_wr_seen_q <= 1'b0;
      vec_q        <= VEC_RESET;
      en_q         <= EN_RESET;
    end else begin
      int_state_q  <= int_state_d;
      retrig_q     <= retrig_d;
      nmi_state_q  <= nmi_state_d;
      pcnt_q       <= pcnt_d;
      io_wr_seen_q <= io_wr_seen_d;
      vec_q        <= vec_d;
      en_q         <= en_d;
    end
  end

  // ---------------------------------------------------------------------------
  // INT FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    int_state_d = int_state_q;
    retrig_d    = retrig_q;

    unique case (int_state_q)
      INT_ST_IDLE: begin
        if (int_ev) int_state_d = INT_ST_PEND;
      end

      INT_ST_PEND: begin
        if (en_wr && !D_IN[0]) begin
          // Masking withdraws a request the CPU has not taken yet.
          int_state_d = INT_ST_IDLE;
        end else if (inta) begin
          int_state_d = INT_ST_ACK;
          // A press landing on the INTA cycle itself must not be lost.
          retrig_d    = int_ev;
        end
      end

      INT_ST_ACK: begin
        retrig_d = retrig_q | int_ev;
        if (nIORQ) begin
          int_state_d = (retrig_q | int_ev) ? INT_ST_PEND : INT_ST_IDLE;
          retrig_d    = 1'b0;
        end
      end

      default: begin
        int_state_d = INT_ST_IDLE;
        retrig_d    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // NMI FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    nmi_state_d = nmi_state_q;
    pcnt_d      = pcnt_q;

    unique case (nmi_state_q)
      NMI_ST_IDLE: begin
        if (nmi_ev) begin
          nmi_state_d = NMI_ST_PULSE;
          pcnt_d      = '0;
        end
      end

      NMI_ST_PULSE: begin
        // Further NMI presses are ignored until the pulse completes.
        if (pcnt_q == PCNT_LAST) begin
          nmi_state_d = NMI_ST_IDLE;
          pcnt_d      = '0;
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end
      end

      default: begin
        nmi_state_d = NMI_ST_IDLE;
        pcnt_d      = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so the pins change on the
  // same edge as the FSMs.
  // ---------------------------------------------------------------------------
  logic nint_q, nint_d;
  logic nnmi_q, nnmi_d;

  always_comb begin
    nint_d = (int_state_d != INT_ST_PEND);
    nnmi_d = (nmi_state_d != NMI_ST_PULSE);
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      nint_q <= 1'b1;
      nnmi_q <= 1'b1;
    end else begin
      nint_q <= nint_d;
      nnmi_q <= nnmi_d;
    end
  end

  assign nINT   = nint_q;
  assign nNMI   = nnmi_q;
  assign VEC    = vec_q;
  assign VEC_OE = inta;

endmodule : key_intr_ctrl

// File: tb/tb_key_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_intr_ctrl
// Directed scenarios (bounce, vector/INTA, masking, retrigger, NMI, reset)
// followed by a randomized run. A behavioural model tracks what nINT, nNMI,
// VEC and VEC_OE must be and is compared against the DUT after every edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_intr_ctrl;

  localparam int         TB_DEB      = 8;
  localparam int         TB_PULSE    = 4;
  localparam logic [7:0] TB_VEC_PORT = 8'h04;
  localparam logic [7:0] TB_EN_PORT  = 8'h05;
  localparam int         HOLD        = TB_DEB + 6;

  logic       clk     = 1'b0;
  logic       n_reset = 1'b0;
  logic       key_int = 1'b0;
  logic       key_nmi = 1'b0;
  logic       n_m1    = 1'b1;
  logic       n_iorq  = 1'b1;
  logic       n_wr    = 1'b1;
  logic [7:0] a_hi    = 8'h00;
  logic [7:0] d_in    = 8'h00;
  logic       n_int;
  logic       n_nmi;
  logic [7:0] vec;
  logic       vec_oe;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  key_intr_ctrl #(
    .DEB_CYCLES (16'(TB_DEB)),
    .NMI_PULSE  (TB_PULSE),
    .VEC_PORT   (TB_VEC_PORT)
  ) dut (
    .CLK     (clk),
    .nRESET  (n_reset),
    .KEY_INT (key_int),
    .KEY_NMI (key_nmi),
    .nM1     (n_m1),
    .nIORQ   (n_iorq),
    .nWR     (n_wr),
    .A_HI    (a_hi),
    .D_IN    (d_in),
    .nINT    (n_int),
    .nNMI    (n_nmi),
    .VEC     (vec),
    .VEC_OE  (vec_oe)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. Keys: index 0 = INT, 1 = NMI.
  //   m_pend / m_ack / m_retrig : maskable request bookkeeping
  //   m_nmi_left                : cycles of nNMI low still to go
  // ---------------------------------------------------------------------------
  bit         m_sync [2][2];
  int         m_run  [2];
  bit         m_db   [2];
  bit         m_ev   [2];
  bit         m_pend, m_ack, m_retrig;
  int         m_nmi_left;
  logic [7:0] m_vec = 8'h80;
  bit         m_en  = 1'b1;
  bit         m_wr_prev;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sync[k][0] = 1'b0;
      m_sync[k][1] = 1'b0;
      m_run[k]     = 0;
      m_db[k]      = 1'b0;
      m_ev[k]      = 1'b0;
    end
    m_pend     = 1'b0;
    m_ack      = 1'b0;
    m_retrig   = 1'b0;
    m_nmi_left = 0;
    m_vec      = 8'h80;
    m_en       = 1'b1;
    m_wr_prev  = 1'b0;
  endfunction

  function automatic void model_step();
    bit inta, wr_now, wr, ev_int, ev_nmi, old_db, synced;
    bit raw [2];
    inta   = !n_m1 && !n_iorq;
    wr_now = !n_iorq && !n_wr && n_m1;
    wr     = wr_now && !m_wr_prev;
    ev_int = m_ev[0] && m_en;
    ev_nmi = m_ev[1];

    // Maskable request
    if (m_pend) begin
      if (wr && a_hi == TB_EN_PORT && !d_in[0]) m_pend = 1'b0;
      else if (inta) begin
        m_pend   = 1'b0;
        m_ack    = 1'b1;
        m_retrig = ev_int;
      end
    end else if (m_ack) begin
      m_retrig = m_retrig || ev_int;
      if (n_iorq) begin
        m_ack    = 1'b0;
        m_pend   = m_retrig;
        m_retrig = 1'b0;
      end
    end else if (ev_int) begin
      m_pend = 1'b1;
    end

    // NMI: a countdown; presses while counting are ignored
    if (m_nmi_left > 0) m_nmi_left--;
    else if (ev_nmi)    m_nmi_left = TB_PULSE;

    // IO registers
    if (wr && a_hi == TB_VEC_PORT) m_vec = d_in;
    if (wr && a_hi == TB_EN_PORT)  m_en  = d_in[0];
    m_wr_prev = wr_now;

    // Keys: level accepted after TB_DEB consecutive disagreeing samples
    raw[0] = key_int;
    raw[1] = key_nmi;
    for (int k = 0; k < 2; k++) begin
      old_db = m_db[k];
      synced = m_sync[k][1];
      if (synced != m_db[k]) begin
        m_run[k]++;
        if (m_run[k] == TB_DEB) begin
          m_db[k]  = synced;
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
      m_ev[k]      = m_db[k] && !old_db;
      m_sync[k][1] = m_sync[k][0];
      m_sync[k][0] = raw[k];
    end
  endfunction

  always @(posedge clk) begin
    if (!n_reset) model_reset();
    else          model_step();
  end

  // Per-cycle comparison, 1 ns after the edge.
  always @(posedge clk) begin
    #1;
    check("cyc_nINT",   8'(n_int),  8'(!m_pend));
    check("cyc_nNMI",   8'(n_nmi),  8'(m_nmi_left == 0));
    check("cyc_VEC",    vec,        m_vec);
    check("cyc_VEC_OE", 8'(vec_oe), 8'(!n_m1 && !n_iorq));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    a_hi = port; d_in = data; n_m1 = 1'b1; n_iorq = 1'b0; n_wr = 1'b0;
    tick(2);
    n_iorq = 1'b1; n_wr = 1'b1;
    tick(1);
  endtask

  task automatic inta_cycle();
    n_m1 = 1'b0; n_iorq = 1'b0;
    tick(2);
    n_m1 = 1'b1; n_iorq = 1'b1;
    tick(1);
  endtask

  task automatic press_int();
    key_int = 1'b1;
    tick(HOLD);
    key_int = 1'b0;
    tick(HOLD);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int   lows, falls, lat, n;
    logic prev;

    // Reset state
    tick(3);
    @(posedge clk); #1;
    check("reset_nINT",   8'(n_int),  8'h01);
    check("reset_nNMI",   8'(n_nmi),  8'h01);
    check("reset_VEC",    vec,        8'h80);
    check("reset_VEC_OE", 8'(vec_oe), 8'h00);
    tick(1);
    n_reset = 1'b1;
    tick(2);

    // Bounce rejection: toggle every 3 cycles, then hold high
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      key_int = ~key_int;
      repeat (3) begin
        @(posedge clk); #1;
        if (!n_int) lows++;
        @(negedge clk);
      end
    end
    check("bounce_quiet", 8'(lows), 8'd0);
    key_int = 1'b1;
    falls = 0; lat = 0; prev = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (!n_int && prev) begin
        falls++;
        if (lat == 0) lat = c;
      end
      prev = n_int;
    end
    check("bounce_latency", 8'(lat),   8'd11);
    check("bounce_single",  8'(falls), 8'd1);
    tick(1);
    inta_cycle();
    key_int = 1'b0;
    tick(HOLD);

    // Vector programming and acknowledge
    io_write(TB_VEC_PORT, 8'h3C);
    press_int();
    check("vec_pend_nINT", 8'(n_int), 8'h00);
    n_m1 = 1'b0; n_iorq = 1'b0;
    #1;
    check("inta_VEC_OE", 8'(vec_oe), 8'h01);
    check("inta_VEC",    vec,        8'h3C);
    @(posedge clk); #1;
    check("inta_nINT_rise", 8'(n_int), 8'h01);
    tick(1);
    n_m1 = 1'b1; n_iorq = 1'b1;
    tick(2);

    // Masking
    press_int();
    check("mask_pend", 8'(n_int), 8'h00);
    a_hi = TB_EN_PORT; d_in = 8'h00; n_m1 = 1'b1; n_iorq = 1'b0; n_wr = 1'b0;
    @(posedge clk); #1;
    check("mask_withdraw", 8'(n_int), 8'h01);
    tick(1);
    n_iorq = 1'b1; n_wr = 1'b1;
    tick(1);
    press_int();
    check("mask_dropped", 8'(n_int), 8'h01);
    io_write(TB_EN_PORT, 8'h01);
    press_int();
    check("unmask_pend", 8'(n_int), 8'h00);
    inta_cycle();

    // Retrigger during ACK
    press_int();
    n_m1 = 1'b0; n_iorq = 1'b0;
    tick(1);
    key_int = 1'b1;
    tick(HOLD);
    check("retrig_ack_high", 8'(n_int), 8'h01);
    key_int = 1'b0;
    n_m1 = 1'b1; n_iorq = 1'b1;
    @(posedge clk); #1;
    check("retrig_pend", 8'(n_int), 8'h00);
    tick(1);
    inta_cycle();
    tick(HOLD);

    // NMI: two key edges 2 cycles apart -> one 4-cycle pulse
    lows = 0; falls = 0; prev = 1'b1;
    for (int i = 0; i < 40; i++) begin
      key_nmi = (i < 2) || (i >= 4 && i < 24);
      @(posedge clk); #1;
      if (!n_nmi) lows++;
      if (!n_nmi && prev) falls++;
      prev = n_nmi;
      @(negedge clk);
    end
    check("nmi_width",  8'(lows),  8'(TB_PULSE));
    check("nmi_single", 8'(falls), 8'd1);

    // Reset mid-operation (INT pending, NMI pulse running)
    key_int = 1'b1;
    tick(HOLD);
    key_int = 1'b0;
    tick(HOLD);
    check("pre_reset_pend", 8'(n_int), 8'h00);
    key_nmi = 1'b1;
    n = 0;
    while (n < 30 && n_nmi) begin
      @(posedge clk); #1;
      n++;
    end
    check("pre_reset_nmi_low", 8'(n_nmi), 8'h00);
    #1;
    n_reset = 1'b0;
    #1;
    check("rst_async_nNMI", 8'(n_nmi), 8'h01);
    check("rst_async_nINT", 8'(n_int), 8'h01);
    key_nmi = 1'b0;
    tick(3);
    n_reset = 1'b1;
    check("rst_vec_readback", vec, 8'h80);
    lows = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (!n_int || !n_nmi) lows++;
    end
    check("rst_no_residual", 8'(lows), 8'd0);
    tick(1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) key_int = ~key_int;
      if ($urandom_range(0, 59) == 0) key_nmi = ~key_nmi;
      case ($urandom_range(0, 7))
        0: begin
          n_m1 = 1'b1; n_iorq = 1'b0; n_wr = 1'b0;
          a_hi = 8'($urandom_range(3, 6));
          d_in = 8'($urandom);
        end
        1: begin
          n_m1 = 1'b0; n_iorq = 1'b0; n_wr = 1'b1;
        end
        2: ;  // hold the previous strobes
        default: begin
          n_m1 = 1'b1; n_iorq = 1'b1; n_wr = 1'b1;
        end
      endcase
      tick(1);
    end
    n_m1 = 1'b1; n_iorq = 1'b1; n_wr = 1'b1;
    tick(2 * HOLD);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule : tb_key_intr_ctrl
